// File: rtl/rggen_address_decoder_pkg.sv
// Shared types and constants for the register-block access sequencer.
// Holds the sequencer state encoding and the response status codes
// returned to the host bus adapter.
package rggen_address_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam logic [1:0] STATUS_OK           = 2'b00;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT      = 2'b11;

endpackage

// File: rtl/rggen_address_range_match.sv
// Single-window address comparator.
// Ports:
//   address - captured command address
//   index   - captured indirect index
//   match   - high when the address falls inside [START_ADDRESS, END_ADDRESS]
//             and, for indirect windows, the index equals INDEX_VALUE
module rggen_address_range_match #(
  parameter int                      ADDRESS_WIDTH = 16,
  parameter int                      INDEX_WIDTH   = 1,
  parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
  parameter logic [ADDRESS_WIDTH-1:0] END_ADDRESS   = '0,
  parameter bit                      INDIRECT      = 1'b0,
  parameter logic [INDEX_WIDTH-1:0]   INDEX_VALUE   = '0
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [INDEX_WIDTH-1:0]   index,
  output logic                     match
);

  localparam logic [ADDRESS_WIDTH-1:0] SPAN = END_ADDRESS - START_ADDRESS;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     address_hit;
  logic                     index_hit;

  // Offset from window start wraps to a large value below the start, so a
  // single unsigned compare against the span covers both bounds. A zero span
  // degenerates to exact equality with the start address.
  always_comb begin
    offset      = address - START_ADDRESS;
    address_hit = (offset <= SPAN);
    index_hit   = INDIRECT ? (index == INDEX_VALUE) : 1'b1;
    match       = address_hit && index_hit;
  end

endmodule

// File: rtl/rggen_address_decoder_array.sv
// Multi-register access sequencer.
// Accepts one host command, decodes it against NUM_REGISTERS windows, drives
// a one-hot select to the winning register until it completes (or times out),
// then returns status and read data over a valid/ready response channel.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   i_command_valid/o_command_ready - command handshake (ready only in IDLE)
//   i_address, i_write, i_indirect_index - command payload
//   o_register_select, o_write - one-hot select and write flag to registers
//   i_register_ready, i_register_read_data - per-register completion and data
//   o_response_valid/i_response_ready - response handshake
//   o_response_status, o_read_data - response payload
module rggen_address_decoder_array
  import rggen_address_decoder_pkg::*;
#(
  parameter int ADDRESS_WIDTH        = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int NUM_REGISTERS        = 4,
  parameter logic [NUM_REGISTERS*ADDRESS_WIDTH-1:0] START_ADDRESSES = '0,
  parameter logic [NUM_REGISTERS*ADDRESS_WIDTH-1:0] END_ADDRESSES   = '0,
  parameter logic [NUM_REGISTERS-1:0] INDIRECT_REGISTERS = '0,
  parameter int INDIRECT_INDEX_WIDTH = 1,
  parameter logic [NUM_REGISTERS*INDIRECT_INDEX_WIDTH-1:0] INDIRECT_INDEX_VALUES = '0,
  parameter int TIMEOUT_CYCLES       = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_command_valid,
  output logic                                o_command_ready,
  input  logic [ADDRESS_WIDTH-1:0]            i_address,
  input  logic                                i_write,
  input  logic [INDIRECT_INDEX_WIDTH-1:0]     i_indirect_index,
  output logic [NUM_REGISTERS-1:0]            o_register_select,
  output logic                                o_write,
  input  logic [NUM_REGISTERS-1:0]            i_register_ready,
  input  logic [NUM_REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
  output logic                                o_response_valid,
  input  logic                                i_response_ready,
  output logic [1:0]                          o_response_status,
  output logic [DATA_WIDTH-1:0]               o_read_data
);

  localparam int COUNT_WIDTH =
    ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                       state;
  state_e                       next_state;
  logic [ADDRESS_WIDTH-1:0]     address_q;
  logic                         write_q;
  logic [INDIRECT_INDEX_WIDTH-1:0] index_q;
  logic [NUM_REGISTERS-1:0]     select_q;
  logic [1:0]                   status_q;
  logic [DATA_WIDTH-1:0]        read_data_q;
  logic [COUNT_WIDTH-1:0]       timeout_count;

  logic [NUM_REGISTERS-1:0]     window_match;
  logic [NUM_REGISTERS-1:0]     hit_select;
  logic                         hit_found;
  logic [DATA_WIDTH-1:0]        selected_data;
  logic                         ready_hit;
  logic                         timeout_hit;

  for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_window
    rggen_address_range_match #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .INDEX_WIDTH   (INDIRECT_INDEX_WIDTH),
      .START_ADDRESS (START_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .END_ADDRESS   (END_ADDRESSES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .INDIRECT      (INDIRECT_REGISTERS[i]),
      .INDEX_VALUE   (INDIRECT_INDEX_VALUES[i*INDIRECT_INDEX_WIDTH +: INDIRECT_INDEX_WIDTH])
    ) u_match (
      .address (address_q),
      .index   (index_q),
      .match   (window_match[i])
    );
  end

  // Priority encoder: overlapping windows resolve to the lowest index so the
  // registered select is always one-hot.
  always_comb begin
    hit_select = '0;
    hit_found  = 1'b0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (window_match[i] && !hit_found) begin
        hit_select[i] = 1'b1;
        hit_found     = 1'b1;
      end
    end
  end

  // Completion is taken only from the selected register; other ready bits
  // are masked off. Timeout fires on the last allowed ACCESS cycle.
  always_comb begin
    selected_data = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (select_q[i]) begin
        selected_data = i_register_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ready_hit   = |(i_register_ready & select_q);
    timeout_hit = (TIMEOUT_CYCLES > 0) && (timeout_count == TIMEOUT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; ready takes precedence over timeout in ACCESS.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_command_valid) next_state = DECODE;
      DECODE:  next_state = hit_found ? ACCESS : RESPOND;
      ACCESS:  if (ready_hit || timeout_hit) next_state = RESPOND;
      RESPOND: if (i_response_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: command capture, decode result, completion capture and the
  // ACCESS-cycle counter. Status and data stay frozen through RESPOND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q     <= '0;
      write_q       <= 1'b0;
      index_q       <= '0;
      select_q      <= '0;
      status_q      <= STATUS_OK;
      read_data_q   <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_command_valid) begin
            address_q   <= i_address;
            write_q     <= i_write;
            index_q     <= i_indirect_index;
            status_q    <= STATUS_OK;
            read_data_q <= '0;
          end
        end
        DECODE: begin
          select_q      <= hit_select;
          timeout_count <= '0;
          if (!hit_found) begin
            status_q    <= STATUS_DECODE_ERROR;
            read_data_q <= '0;
          end
        end
        ACCESS: begin
          if (ready_hit) begin
            status_q    <= STATUS_OK;
            read_data_q <= write_q ? '0 : selected_data;
            select_q    <= '0;
          end else if (timeout_hit) begin
            status_q    <= STATUS_TIMEOUT;
            read_data_q <= '0;
            select_q    <= '0;
          end else if (TIMEOUT_CYCLES > 0) begin
            timeout_count <= timeout_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; the select is gated by state so an asynchronous reset drops it
  // immediately.
  always_comb begin
    o_command_ready   = (state == IDLE);
    o_register_select = (state == ACCESS) ? select_q : '0;
    o_write           = write_q;
    o_response_valid  = (state == RESPOND);
    o_response_status = status_q;
    o_read_data       = read_data_q;
  end

endmodule

// File: tb/tb_rggen_address_decoder_array.sv
// Directed self-checking bench for the register-block access sequencer.
// Main instance: w0=0x00, w1=0x10..0x1F, w2=0x20 with index 1, timeout 4.
// Second instance overlaps w0 onto 0x10 to exercise the priority encoder.
module tb_rggen_address_decoder_array;

  logic        clk;
  logic        rst_n;
  logic        command_valid;
  logic        command_ready;
  logic [7:0]  address;
  logic        write;
  logic [1:0]  indirect_index;
  logic [2:0]  register_select;
  logic        write_out;
  logic [2:0]  register_ready;
  logic [95:0] register_read_data;
  logic        response_valid;
  logic        response_ready;
  logic [1:0]  response_status;
  logic [31:0] read_data;

  logic        m_command_valid;
  logic        m_command_ready;
  logic [7:0]  m_address;
  logic [2:0]  m_register_select;
  logic        m_write_out;
  logic [2:0]  m_register_ready;
  logic        m_response_valid;
  logic        m_response_ready;
  logic [1:0]  m_response_status;
  logic [31:0] m_read_data;

  int vectors;
  int miscompares;

  rggen_address_decoder_array #(
    .ADDRESS_WIDTH        (8),
    .DATA_WIDTH           (32),
    .NUM_REGISTERS        (3),
    .START_ADDRESSES      ({8'h20, 8'h10, 8'h00}),
    .END_ADDRESSES        ({8'h20, 8'h1F, 8'h00}),
    .INDIRECT_REGISTERS   (3'b100),
    .INDIRECT_INDEX_WIDTH (2),
    .INDIRECT_INDEX_VALUES({2'h1, 2'h0, 2'h0}),
    .TIMEOUT_CYCLES       (4)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_command_valid      (command_valid),
    .o_command_ready      (command_ready),
    .i_address            (address),
    .i_write              (write),
    .i_indirect_index     (indirect_index),
    .o_register_select    (register_select),
    .o_write              (write_out),
    .i_register_ready     (register_ready),
    .i_register_read_data (register_read_data),
    .o_response_valid     (response_valid),
    .i_response_ready     (response_ready),
    .o_response_status    (response_status),
    .o_read_data          (read_data)
  );

  rggen_address_decoder_array #(
    .ADDRESS_WIDTH        (8),
    .DATA_WIDTH           (32),
    .NUM_REGISTERS        (3),
    .START_ADDRESSES      ({8'h20, 8'h10, 8'h10}),
    .END_ADDRESSES        ({8'h20, 8'h1F, 8'h10}),
    .INDIRECT_REGISTERS   (3'b100),
    .INDIRECT_INDEX_WIDTH (2),
    .INDIRECT_INDEX_VALUES({2'h1, 2'h0, 2'h0}),
    .TIMEOUT_CYCLES       (4)
  ) dut_overlap (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_command_valid      (m_command_valid),
    .o_command_ready      (m_command_ready),
    .i_address            (m_address),
    .i_write              (1'b0),
    .i_indirect_index     (2'h0),
    .o_register_select    (m_register_select),
    .o_write              (m_write_out),
    .i_register_ready     (m_register_ready),
    .i_register_read_data (register_read_data),
    .o_response_valid     (m_response_valid),
    .i_response_ready     (m_response_ready),
    .o_response_status    (m_response_status),
    .o_read_data          (m_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command in IDLE; returns with the DUT in DECODE.
  task automatic issue(input logic [7:0] addr, input logic wr, input logic [1:0] idx);
    address        = addr;
    write          = wr;
    indirect_index = idx;
    command_valid  = 1'b1;
    step();
    command_valid  = 1'b0;
  endtask

  // Complete the response handshake; returns with the DUT back in IDLE.
  task automatic handshake();
    response_ready = 1'b1;
    step();
    response_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (register_select !== 3'b000 || response_valid !== 1'b0 || write_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got sel=%b valid=%b write=%b, expected 000/0/0",
               register_select, response_valid, write_out);
    end
    vectors++;
    if (response_status !== 2'b00 || read_data !== 32'h0 || command_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got status=%b data=%h cready=%b, expected 00/0/1",
               response_status, read_data, command_ready);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_hit();
    register_read_data = {32'h22222222, 32'hCAFE0001, 32'h11111111};
    issue(8'h14, 1'b0, 2'h0);
    vectors++;
    if (register_select !== 3'b000 || response_valid !== 1'b0 || command_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_decode_cycle: got sel=%b valid=%b cready=%b, expected 000/0/0",
               register_select, response_valid, command_ready);
    end
    register_ready = 3'b010;
    step();
    vectors++;
    if (register_select !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL read_select: got %b expected 010", register_select);
    end
    step();
    register_ready = 3'b000;
    vectors++;
    if (response_valid !== 1'b1 || response_status !== 2'b00 || read_data !== 32'hCAFE0001) begin
      miscompares++;
      $display("[TB] FAIL read_response: got valid=%b status=%b data=%h, expected 1/00/cafe0001",
               response_valid, response_status, read_data);
    end
    vectors++;
    if (register_select !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL read_respond_select: got %b expected 000", register_select);
    end
    handshake();
    vectors++;
    if (response_valid !== 1'b0 || command_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL read_return_idle: got valid=%b cready=%b, expected 0/1",
               response_valid, command_ready);
    end
  endtask

  task automatic test_indirect();
    register_read_data = {32'h22222222, 32'hCAFE0001, 32'h11111111};
    issue(8'h20, 1'b0, 2'h1);
    register_ready = 3'b111;
    step();
    vectors++;
    if (register_select !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL indirect_select: got %b expected 100", register_select);
    end
    step();
    register_ready = 3'b000;
    vectors++;
    if (response_valid !== 1'b1 || response_status !== 2'b00 || read_data !== 32'h22222222) begin
      miscompares++;
      $display("[TB] FAIL indirect_response: got valid=%b status=%b data=%h, expected 1/00/22222222",
               response_valid, response_status, read_data);
    end
    handshake();
    issue(8'h20, 1'b0, 2'h2);
    register_ready = 3'b111;
    step();
    register_ready = 3'b000;
    vectors++;
    if (register_select !== 3'b000 || response_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL miss_timing: got sel=%b valid=%b, expected 000/1", register_select, response_valid);
    end
    vectors++;
    if (response_status !== 2'b10 || read_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL miss_response: got status=%b data=%h, expected 10/0", response_status, read_data);
    end
    handshake();
  endtask

  task automatic test_timeout();
    register_read_data = {32'h22222222, 32'hCAFE0001, 32'h11111111};
    issue(8'h00, 1'b1, 2'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (register_select !== 3'b001 || response_valid !== 1'b0 || write_out !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL timeout_access_%0d: got sel=%b valid=%b write=%b, expected 001/0/1",
                 k, register_select, response_valid, write_out);
      end
      step();
    end
    vectors++;
    if (register_select !== 3'b000 || response_valid !== 1'b1 ||
        response_status !== 2'b11 || read_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL timeout_response: got sel=%b valid=%b status=%b data=%h, expected 000/1/11/0",
               register_select, response_valid, response_status, read_data);
    end
    handshake();
    issue(8'h00, 1'b1, 2'h0);
    step();
    step();
    step();
    step();
    register_ready = 3'b001;
    vectors++;
    if (register_select !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL late_ready_select: got %b expected 001", register_select);
    end
    step();
    register_ready = 3'b000;
    vectors++;
    if (response_valid !== 1'b1 || response_status !== 2'b00 || read_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL late_ready_response: got valid=%b status=%b data=%h, expected 1/00/0",
               response_valid, response_status, read_data);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    register_read_data = {32'h22222222, 32'hCAFE0001, 32'h11111111};
    issue(8'h14, 1'b0, 2'h0);
    register_ready = 3'b010;
    step();
    step();
    register_ready = 3'b000;
    address        = 8'h15;
    write          = 1'b0;
    command_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (response_valid !== 1'b1 || response_status !== 2'b00 ||
          read_data !== 32'hCAFE0001 || command_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: got valid=%b status=%b data=%h cready=%b, expected 1/00/cafe0001/0",
                 k, response_valid, response_status, read_data, command_ready);
      end
      step();
    end
    response_ready = 1'b1;
    step();
    response_ready = 1'b0;
    vectors++;
    if (command_ready !== 1'b1 || response_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got cready=%b valid=%b, expected 1/0", command_ready, response_valid);
    end
    step();
    command_valid = 1'b0;
    vectors++;
    if (command_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL next_accept: got cready=%b expected 0", command_ready);
    end
    register_read_data[63:32] = 32'hCAFE0002;
    register_ready = 3'b010;
    step();
    step();
    register_ready = 3'b000;
    vectors++;
    if (response_valid !== 1'b1 || read_data !== 32'hCAFE0002) begin
      miscompares++;
      $display("[TB] FAIL next_response: got valid=%b data=%h, expected 1/cafe0002", response_valid, read_data);
    end
    handshake();
  endtask

  task automatic test_reset_abort();
    issue(8'h00, 1'b0, 2'h0);
    step();
    vectors++;
    if (register_select !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL abort_pre_select: got %b expected 001", register_select);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (register_select !== 3'b000 || response_valid !== 1'b0 || command_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_async: got sel=%b valid=%b cready=%b, expected 000/0/1",
               register_select, response_valid, command_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if (response_valid !== 1'b0 || command_ready !== 1'b1 || register_select !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL abort_stale_%0d: got valid=%b cready=%b sel=%b, expected 0/1/000",
                 k, response_valid, command_ready, register_select);
      end
    end
  endtask

  task automatic test_multi_hit();
    register_read_data = {32'h22222222, 32'hCAFE0001, 32'h11111111};
    m_register_ready   = 3'b111;
    m_address          = 8'h10;
    m_command_valid    = 1'b1;
    step();
    m_command_valid    = 1'b0;
    step();
    vectors++;
    if (m_register_select !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL multi_hit_select: got %b expected 001", m_register_select);
    end
    step();
    vectors++;
    if (m_response_valid !== 1'b1 || m_response_status !== 2'b00 || m_read_data !== 32'h11111111) begin
      miscompares++;
      $display("[TB] FAIL multi_hit_response: got valid=%b status=%b data=%h, expected 1/00/11111111",
               m_response_valid, m_response_status, m_read_data);
    end
    m_response_ready = 1'b1;
    step();
    m_response_ready = 1'b0;
    m_register_ready = 3'b000;
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst_n              = 1'b0;
    command_valid      = 1'b0;
    address            = 8'h00;
    write              = 1'b0;
    indirect_index     = 2'h0;
    register_ready     = 3'b000;
    register_read_data = '0;
    response_ready     = 1'b0;
    m_command_valid    = 1'b0;
    m_address          = 8'h00;
    m_register_ready   = 3'b000;
    m_response_ready   = 1'b0;

    test_reset();
    test_read_hit();
    test_indirect();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    test_multi_hit();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rggen_address_decoder_array.md
Name: rggen_address_decoder_array

Overview:
- Multi-register access sequencer for the register block.
- Accepts one host command at a time (address, write flag, indirect index) and decodes it against NUM_REGISTERS address windows. Each window may optionally be qualified by an indirect index.
- Drives a one-hot select to the winning register and waits for its completion, with an optional timeout.
- Returns read data and a status through a valid/ready response channel. Sits between the host bus adapter and the register instances.

Parameters:
- ADDRESS_WIDTH, 16, width of command address
- DATA_WIDTH, 32, register read-data width
- NUM_REGISTERS, 4, number of decoded windows (>=1)
- START_ADDRESSES, all 0, packed [NUM_REGISTERS*ADDRESS_WIDTH]; entry i is the inclusive window start
- END_ADDRESSES, all 0, packed [NUM_REGISTERS*ADDRESS_WIDTH]; entry i is the inclusive window end (>= start)
- INDIRECT_REGISTERS, 0, bitmask [NUM_REGISTERS]; bit i=1 means window i also requires an index match
- INDIRECT_INDEX_WIDTH, 1, width of indirect index
- INDIRECT_INDEX_VALUES, all 0, packed [NUM_REGISTERS*INDIRECT_INDEX_WIDTH]; required index per window
- TIMEOUT_CYCLES, 0, ACCESS-state cycle limit; 0 disables the timeout

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_command_valid  input  1  command request
- o_command_ready  output  1  command accept
- i_address  input  ADDRESS_WIDTH  command address
- i_write  input  1  1=write, 0=read
- i_indirect_index  input  INDIRECT_INDEX_WIDTH  indirect index
- o_register_select  output  NUM_REGISTERS  one-hot select, held for the whole access
- o_write  output  1  captured write flag
- i_register_ready  input  NUM_REGISTERS  per-register completion
- i_register_read_data  input  NUM_REGISTERS*DATA_WIDTH  packed read data
- o_response_valid  output  1  response available
- i_response_ready  input  1  response accept
- o_response_status  output  2  00 OK, 10 decode error, 11 timeout
- o_read_data  output  DATA_WIDTH  read data (0 for writes and errors)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, all captured registers and the counter cleared.
  - o_register_select, o_write, o_response_valid, o_response_status and o_read_data are 0.
  - o_command_ready=1.
- Reset mid-access aborts immediately. No response is produced for the aborted command.
- State machine: IDLE -> DECODE -> ACCESS -> RESPOND -> IDLE, plus DECODE -> RESPOND on a miss.
- IDLE:
  - o_command_ready=1 only in IDLE.
  - On i_command_valid & o_command_ready, capture address, write and index, then go to DECODE.
- DECODE (exactly 1 cycle), match rule for window i:
  - If start==end: exact equality.
  - Otherwise: start <= addr <= end, unsigned.
  - If INDIRECT_REGISTERS[i]=1, the captured index must also equal INDIRECT_INDEX_VALUES[i].
- DECODE outcome:
  - Multiple hits: the lowest index wins, so select is always one-hot.
  - Hit: register the select, go to ACCESS.
  - No hit: status=10, go to RESPOND.
- ACCESS:
  - o_register_select and o_write are driven from registers.
  - When i_register_ready[sel] is high, capture the selected read data (reads only; writes capture 0), set status=00 and go to RESPOND.
  - Ready bits of unselected registers are ignored.
- Timeout:
  - If TIMEOUT_CYCLES>0, a counter increments each ACCESS cycle.
  - If the count reaches TIMEOUT_CYCLES-1 with no ready, go to RESPOND with status=11 and data=0.
  - If ready and timeout occur in the same cycle, ready wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. The counter clears on entering ACCESS.
- RESPOND:
  - o_response_valid=1. Status and data are stable until the handshake.
  - On i_response_ready, return to IDLE.
  - o_register_select is 0 in RESPOND.
- Minimum latency, with the command accepted at cycle T and ready on the first ACCESS cycle:
  - DECODE at T+1.
  - Select high at T+2, ready sampled at T+2.
  - o_response_valid at T+3.
  - Decode-miss response at T+2.
- Throughput: at most one outstanding command.

Decomposition:
- Package rggen_address_decoder_pkg holds:
  - the state enum (IDLE, DECODE, ACCESS, RESPOND);
  - status constants STATUS_OK=2'b00, STATUS_DECODE_ERROR=2'b10, STATUS_TIMEOUT=2'b11.
- Sub-module rggen_address_range_match: single-window combinational comparator (address range + optional index match). It is generated NUM_REGISTERS times and followed by a priority encoder in the top.

Test Plan:
Common configuration: ADDRESS_WIDTH=8, DATA_WIDTH=32, NUM_REGISTERS=3, windows w0=0x00..0x00, w1=0x10..0x1F, w2=0x20 indirect with index 2'h1 (INDIRECT_INDEX_WIDTH=2), TIMEOUT_CYCLES=4.
- Read 0x14, ready on the first ACCESS cycle with data[1]=0xCAFE0001 -> select=3'b010 at T+2; response at T+3 with status 00 and data 0xCAFE0001.
- Read 0x20 with index 2'h1 -> select 3'b100. Read 0x20 with index 2'h2 -> no select; response at T+2 with status 10 and data 0.
- Write 0x00, ready withheld -> select 3'b001 for exactly 4 cycles, then status 11, data 0. A variant asserting ready on the 4th ACCESS cycle returns status 00.
- Hold i_response_ready=0 for 5 cycles -> valid, status and data stable; o_command_ready=0 throughout; a new command is accepted only after the handshake.
- Assert rst_n low during ACCESS -> select and response_valid drop to 0 asynchronously; after release o_command_ready=1 and no stale response appears.
- Multi-hit: overlap w0 with w1 (w0=0x10..0x10), then read 0x10 -> select 3'b001 only.
